umai_master_rx: RTL
===================

Name: umai_master_rx

Overview:
- Far-side receive stage that directly consumes the AIB flits produced by the UMAI slave bridge.
- Decodes command flits from the lowest active channel into UMAI master write and read command outputs.
- Packs 64-bit write-data words arriving across channels c_first_chn_id..c_last_chn_id back into 512-bit UMAI write beats.
- Sits between the AIB RX channels and the remote UMAI master interface (memory or NoC side).

Parameters:
- NumChannels, 6, number of AIB channels (must be ≤ 8).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- c_first_chn_id  in  3  lowest active channel; static while out of reset.
- c_last_chn_id  in  3  highest active channel; static while out of reset; ≥ c_first_chn_id.
- i_rx_valid  in  1 [NumChannels]  per-channel flit valid.
- o_rx_ready  out  1 [NumChannels]  per-channel flit accept.
- i_rx_data  in  72 [NumChannels]  flit payload.
- o_umai_wcmd_valid / i_umai_wcmd_ready  out/in  1  write-command handshake.
- o_umai_wcmd_addr / o_umai_wcmd_len  out  32 / 6  write-command fields.
- o_umai_rcmd_valid / i_umai_rcmd_ready  out/in  1  read-command handshake.
- o_umai_rcmd_addr / o_umai_rcmd_len  out  32 / 6  read-command fields.
- o_umai_wvalid / i_umai_wready  out/in  1  write-data handshake.
- o_umai_wdata  out  512  write-data beat; word j = bits 64j+63:64j.
- o_err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Flit format:
  - Command flit: bit71=1, bit70=1 write / 0 read, [37:32]=len, [31:0]=addr.
  - Data flit: bit71=0, bit64=word valid, [63:0]=word.
- Reset: every output 0, o_rx_ready all 0, packer count 0, command and beat registers empty.
- Command path:
  - cmd_present = i_rx_valid[first] & i_rx_data[first][71].
  - Each command type has a one-entry output register.
  - o_rx_ready[first] is asserted for a command when the matching register is empty or is being popped this cycle (valid & ready).
  - Accepted command appears on the outputs the next cycle and holds stable until ready.
  - A write command on the channel never blocks a read-register slot, and vice versa.
- Data path:
  - Data channel range: lo = cmd_present ? first+1 : first; hi = last.
  - If lo > hi, no data is taken this cycle.
  - A data set is acceptable only when every channel lo..hi is valid with bit71=0.
  - k = number of channels in lo..hi with bit64=1. Valid words are taken in ascending channel order.
- Packer:
  - Accumulator of 8 words, count cnt 0..7.
  - If cnt+k < 8: accept; words are appended; cnt += k.
  - If cnt+k ≥ 8: accept only when the beat register is empty or draining this cycle. The beat is acc[0..cnt-1] plus the first 8-cnt new words. The remainder is stored at acc[0..]; cnt = cnt+k-8.
  - On accept, o_rx_ready is asserted on all of lo..hi together, never a subset.
  - A set with k=0 is accepted and dropped.
- Latency and ordering:
  - o_umai_wvalid rises the cycle after the 8th word is accepted.
  - Full throughput: one beat per cycle while i_umai_wready is held.
  - A command and data in the same cycle are handled independently.
  - No ordering is enforced between the wcmd and wdata outputs.
- Reset mid-operation: partial words and held commands are discarded; no output glitches after reset deasserts.

Optional Feature:
- Macro: UMAI_MASTER_RX_CHECK_EN.
- When defined:
  - A 12-bit counter of expected beats is added by len+1 on each wcmd acceptance and decremented per emitted beat. Same-cycle add and subtract are both applied.
  - o_err is set when a beat is emitted with the counter at 0.
  - o_err is also set when a data flit is accepted with nonzero bits [70:65].
  - o_err clears only on reset.
- When undefined: o_err is tied 0 and no counter is present.

Decomposition:
- umai_pkg holds:
  - Flit bit-position constants (FLIT_CMD_BIT=71, FLIT_WR_BIT=70, FLIT_WVALID_BIT=64, LEN and ADDR slices).
  - A cmd_t struct {len[5:0], addr[31:0]}.
- One sub-module, umai_rx_word_packer: accumulator, cnt, beat register, and the accept decision.

Test Plan:
- Reset: i_rst=1 for 2 cycles with random rx inputs → all outputs 0, o_rx_ready all 0; first flit is accepted only after deassertion.
- Write command, first=0, last=5: ch0 = {1,1,32'b0,6'd3,32'h1000_0040} → next cycle wcmd_valid=1, addr=0x10000040, len=3.
  - Hold wcmd_ready=0 and send a second write command → o_rx_ready[0]=0 until pop.
  - A read command is still accepted in parallel.
- Packing, no command: cycle 1 ch0..5 carry W0..W5 valid; cycle 2 ch0..1 carry W6,W7 valid, ch2..5 bit64=0 → one beat {W7..W0}, cnt=0.
- Command plus data: ch0 read command (len=0, addr=0x20), ch1..5 carry 5 words; next set 3 words → rcmd_valid and one wdata beat in word order; rx_ready[0..5] all asserted in the first cycle.
- Backpressure: beat pending, i_umai_wready=0, cnt=6, 6 new words → data ready low, no loss; release → two beats, cnt=4.
- With UMAI_MASTER_RX_CHECK_EN: wcmd len=0 then 2 beats → o_err=1 on the second beat and stays 1 until reset.

Source files
------------

// File: rtl/umai_pkg.sv
// umai_pkg: shared definitions for the UMAI master receive path.
//   - AIB flit bit positions (command and data flit layouts)
//   - cmd_t: decoded command fields
//   - flit_to_cmd(): extracts len/addr from a command flit
package umai_pkg;

    localparam int unsigned FLIT_W          = 72;
    localparam int unsigned FLIT_CMD_BIT    = 71;
    localparam int unsigned FLIT_WR_BIT     = 70;
    localparam int unsigned FLIT_WVALID_BIT = 64;
    localparam int unsigned FLIT_RSVD_MSB   = 70;
    localparam int unsigned FLIT_RSVD_LSB   = 65;
    localparam int unsigned FLIT_LEN_MSB    = 37;
    localparam int unsigned FLIT_LEN_LSB    = 32;
    localparam int unsigned FLIT_ADDR_MSB   = 31;
    localparam int unsigned FLIT_ADDR_LSB   = 0;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned BEAT_WORDS = 8;
    localparam int unsigned BEAT_W     = WORD_W * BEAT_WORDS;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic [5:0]  len;
        logic [31:0] addr;
    } cmd_t;

    function automatic cmd_t flit_to_cmd(input logic [FLIT_W-1:0] flit);
        cmd_t c;
        c.len  = flit[FLIT_LEN_MSB:FLIT_LEN_LSB];
        c.addr = flit[FLIT_ADDR_MSB:FLIT_ADDR_LSB];
        return c;
    endfunction

endpackage

// File: rtl/umai_rx_word_packer.sv
// umai_rx_word_packer: gathers 64-bit words into 512-bit write beats.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i            a complete data set is offered this cycle
//   in_k_i, in_words_i    number of valid words (0..8), compacted in order
//   in_accept_o           data set taken this cycle (all-or-nothing)
//   beat_valid_o/ready_i  output beat handshake
//   beat_data_o           beat, word j at bits 64j+63:64j
module umai_rx_word_packer
    import umai_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [3:0]        in_k_i,
    input  word_t             in_words_i [BEAT_WORDS],
    output logic              in_accept_o,
    output logic              beat_valid_o,
    input  logic              beat_ready_i,
    output logic [BEAT_W-1:0] beat_data_o
);

    logic [2:0]        cnt_q, cnt_d;
    word_t             acc_q [BEAT_WORDS];
    word_t             acc_d [BEAT_WORDS];
    logic              beat_valid_q, beat_valid_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    // Held words followed by the new words; the first 8 form a beat when full.
    word_t             merged [2*BEAT_WORDS];
    logic [4:0]        total;
    logic              full;
    logic              beat_free;

    always_comb begin
        total     = {2'b00, cnt_q} + {1'b0, in_k_i};
        full      = (total >= 5'd8);
        beat_free = !beat_valid_q || beat_ready_i;
        in_accept_o = in_valid_i && (!full || beat_free);

        for (int i = 0; i < 2*BEAT_WORDS; i++) begin
            int off;
            merged[i] = '0;
            off = i - int'(cnt_q);
            if (i < int'(cnt_q)) begin
                merged[i] = acc_q[3'(i)];
            end else if (off < BEAT_WORDS) begin
                merged[i] = in_words_i[off[2:0]];
            end
        end

        cnt_d        = cnt_q;
        acc_d        = acc_q;
        beat_d       = beat_q;
        beat_valid_d = beat_valid_q && !beat_ready_i;

        if (in_accept_o) begin
            if (full) begin
                beat_valid_d = 1'b1;
                for (int j = 0; j < BEAT_WORDS; j++) begin
                    beat_d[WORD_W*j +: WORD_W] = merged[j];
                    acc_d[j] = merged[j+BEAT_WORDS];
                end
                cnt_d = 3'(total - 5'd8);
            end else begin
                for (int j = 0; j < BEAT_WORDS; j++) begin
                    acc_d[j] = merged[j];
                end
                cnt_d = total[2:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            beat_valid_q <= 1'b0;
            beat_q       <= '0;
            for (int j = 0; j < BEAT_WORDS; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            beat_valid_q <= beat_valid_d;
            beat_q       <= beat_d;
            acc_q        <= acc_d;
        end
    end

    assign beat_valid_o = beat_valid_q;
    assign beat_data_o  = beat_q;

endmodule

// File: rtl/umai_master_rx.sv
// umai_master_rx: far-side receive stage turning AIB flits back into UMAI
// master write/read commands and 512-bit write-data beats.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   c_first_chn_id, c_last_chn_id     active channel window (static)
//   i_rx_valid/o_rx_ready/i_rx_data   per-channel AIB flit interface
//   o_umai_wcmd_*, i_umai_wcmd_ready  write command output
//   o_umai_rcmd_*, i_umai_rcmd_ready  read command output
//   o_umai_wvalid/wdata, i_umai_wready write-data beat output
//   o_err                             sticky protocol error
// Build option: define UMAI_MASTER_RX_CHECK_EN to enable the beat-count and
// reserved-bit checker driving o_err; otherwise o_err is tied low.
module umai_master_rx
    import umai_pkg::*;
#(
    parameter int unsigned NumChannels = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2:0]             c_first_chn_id,
    input  logic [2:0]             c_last_chn_id,
    input  logic [NumChannels-1:0] i_rx_valid,
    output logic [NumChannels-1:0] o_rx_ready,
    input  logic [FLIT_W-1:0]      i_rx_data [NumChannels],
    output logic                   o_umai_wcmd_valid,
    input  logic                   i_umai_wcmd_ready,
    output logic [31:0]            o_umai_wcmd_addr,
    output logic [5:0]             o_umai_wcmd_len,
    output logic                   o_umai_rcmd_valid,
    input  logic                   i_umai_rcmd_ready,
    output logic [31:0]            o_umai_rcmd_addr,
    output logic [5:0]             o_umai_rcmd_len,
    output logic                   o_umai_wvalid,
    input  logic                   i_umai_wready,
    output logic [BEAT_W-1:0]      o_umai_wdata,
    output logic                   o_err
);

    logic [FLIT_W-1:0]      first_flit;
    logic                   first_valid;
    logic                   cmd_present;
    logic                   wcmd_accept, rcmd_accept;
    logic [3:0]             lo, hi;
    logic [NumChannels-1:0] in_range;
    logic                   set_ok;
    logic [3:0]             k;
    word_t                  words [BEAT_WORDS];
    logic                   data_accept;

    logic wcmd_valid_q, rcmd_valid_q;
    cmd_t wcmd_q, rcmd_q;

    // Select the flit on the first active channel without a variable index.
    always_comb begin
        first_flit  = '0;
        first_valid = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (3'(c) == c_first_chn_id) begin
                first_flit  = i_rx_data[c];
                first_valid = i_rx_valid[c];
            end
        end
    end

    assign cmd_present = first_valid && first_flit[FLIT_CMD_BIT];

    // A slot is free when empty or being popped this cycle.
    assign wcmd_accept = !i_rst && cmd_present && first_flit[FLIT_WR_BIT] &&
                         (!wcmd_valid_q || i_umai_wcmd_ready);
    assign rcmd_accept = !i_rst && cmd_present && !first_flit[FLIT_WR_BIT] &&
                         (!rcmd_valid_q || i_umai_rcmd_ready);

    // Data window skips the first channel when it carries a command.
    always_comb begin
        lo     = {1'b0, c_first_chn_id} + {3'b000, cmd_present};
        hi     = {1'b0, c_last_chn_id};
        set_ok = (lo <= hi) && (hi < 4'(NumChannels));
        k      = '0;
        for (int j = 0; j < BEAT_WORDS; j++) begin
            words[j] = '0;
        end
        for (int c = 0; c < NumChannels; c++) begin
            in_range[c] = (4'(c) >= lo) && (4'(c) <= hi);
            if (in_range[c]) begin
                if (!i_rx_valid[c] || i_rx_data[c][FLIT_CMD_BIT]) begin
                    set_ok = 1'b0;
                end
                if (i_rx_data[c][FLIT_WVALID_BIT]) begin
                    if (k < 4'd8) begin
                        words[k[2:0]] = i_rx_data[c][WORD_W-1:0];
                    end
                    k = k + 4'd1;
                end
            end
        end
    end

    umai_rx_word_packer u_packer (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .in_valid_i   (set_ok && !i_rst),
        .in_k_i       (k),
        .in_words_i   (words),
        .in_accept_o  (data_accept),
        .beat_valid_o (o_umai_wvalid),
        .beat_ready_i (i_umai_wready),
        .beat_data_o  (o_umai_wdata)
    );

    always_comb begin
        o_rx_ready = '0;
        for (int c = 0; c < NumChannels; c++) begin
            o_rx_ready[c] = (in_range[c] && data_accept) ||
                            ((3'(c) == c_first_chn_id) && (wcmd_accept || rcmd_accept));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wcmd_valid_q <= 1'b0;
            rcmd_valid_q <= 1'b0;
            wcmd_q       <= '0;
            rcmd_q       <= '0;
        end else begin
            if (wcmd_accept) begin
                wcmd_valid_q <= 1'b1;
                wcmd_q       <= flit_to_cmd(first_flit);
            end else if (i_umai_wcmd_ready) begin
                wcmd_valid_q <= 1'b0;
            end
            if (rcmd_accept) begin
                rcmd_valid_q <= 1'b1;
                rcmd_q       <= flit_to_cmd(first_flit);
            end else if (i_umai_rcmd_ready) begin
                rcmd_valid_q <= 1'b0;
            end
        end
    end

    assign o_umai_wcmd_valid = wcmd_valid_q;
    assign o_umai_wcmd_addr  = wcmd_q.addr;
    assign o_umai_wcmd_len   = wcmd_q.len;
    assign o_umai_rcmd_valid = rcmd_valid_q;
    assign o_umai_rcmd_addr  = rcmd_q.addr;
    assign o_umai_rcmd_len   = rcmd_q.len;

    // Command flit bits between len and the type bits carry nothing.
    logic unused_first_bits;
    assign unused_first_bits = ^first_flit[69:38];

`ifdef UMAI_MASTER_RX_CHECK_EN
    logic [11:0] exp_beats_q, exp_beats_d;
    logic        err_q, err_d;
    logic        beat_pop;
    logic        rsvd_bad;

    assign beat_pop = o_umai_wvalid && i_umai_wready;

    always_comb begin
        rsvd_bad = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (in_range[c] && |i_rx_data[c][FLIT_RSVD_MSB:FLIT_RSVD_LSB]) begin
                rsvd_bad = 1'b1;
            end
        end
        exp_beats_d = exp_beats_q;
        if (wcmd_accept) begin
            exp_beats_d = exp_beats_d + 12'(flit_to_cmd(first_flit).len) + 12'd1;
        end
        if (beat_pop && (exp_beats_q != '0)) begin
            exp_beats_d = exp_beats_d - 12'd1;
        end
        err_d = err_q || (beat_pop && (exp_beats_q == '0)) || (data_accept && rsvd_bad);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exp_beats_q <= '0;
            err_q       <= 1'b0;
        end else begin
            exp_beats_q <= exp_beats_d;
            err_q       <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
